// File: rtl/cpu_mem_ctrl.sv
// rtl/cpu_mem_ctrl.sv - CPU load/store port to 32-bit byte-enabled pipelined Wishbone adapter
module cpu_mem_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [2:0]  i_sel,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_mem_wb_data,
    input  logic [31:0] i_mem_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall
);
    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2} state_t;

    state_t      r_state;
    logic [1:0]  r_offset;
    logic [2:0]  r_size;
    logic        r_split;
    logic [29:0] r_word_hi;
    logic [3:0]  r_sel_hi;
    logic [31:0] r_data_hi;
    logic [31:0] r_rd_lo;

    logic [3:0]  w_base;
    logic [31:0] w_store;
    logic [7:0]  w_mask;
    logic [63:0] w_lanes;
    logic [63:0] w_raw;
    logic [31:0] w_shifted;
    logic [31:0] w_result;

    // Request viewed as an 8-lane window across two words; upper half is the spill access.
    always_comb begin
        case (i_sel[1:0])
            2'b00: begin
                w_base  = 4'b0001;
                w_store = {24'h0, i_wb_data[7:0]};
            end
            2'b01: begin
                w_base  = 4'b0011;
                w_store = {16'h0, i_wb_data[15:0]};
            end
            default: begin
                w_base  = 4'b1111;
                w_store = i_wb_data;
            end
        endcase
    end

    assign w_mask  = {4'b0000, w_base} << i_wb_addr[1:0];
    assign w_lanes = i_wb_we ? ({32'h0, w_store} << {i_wb_addr[1:0], 3'b000}) : 64'h0;

    assign w_raw     = (r_state == WAIT2) ? {i_mem_wb_data, r_rd_lo} : {32'h0, i_mem_wb_data};
    assign w_shifted = w_raw[{r_offset, 3'b000} +: 32];

    always_comb begin
        case (r_size[1:0])
            2'b00:   w_result = {{24{~r_size[2] & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_result = {{16{~r_size[2] & w_shifted[15]}}, w_shifted[15:0]};
            default: w_result = w_shifted;
        endcase
    end

    assign o_wb_stall = (r_state != IDLE);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= IDLE;
            r_offset      <= '0;
            r_size        <= '0;
            r_split       <= 1'b0;
            r_word_hi     <= '0;
            r_sel_hi      <= '0;
            r_data_hi     <= '0;
            r_rd_lo       <= '0;
            o_wb_data     <= '0;
            o_wb_ack      <= 1'b0;
            o_wb_stb      <= 1'b0;
            o_wb_we       <= 1'b0;
            o_wb_addr     <= '0;
            o_wb_sel      <= '0;
            o_mem_wb_data <= '0;
        end else begin
            o_wb_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_wb_stb) begin
                        r_state       <= REQ1;
                        r_offset      <= i_wb_addr[1:0];
                        r_size        <= i_sel;
                        r_split       <= |w_mask[7:4];
                        r_word_hi     <= i_wb_addr[31:2] + 30'd1;
                        r_sel_hi      <= w_mask[7:4];
                        r_data_hi     <= w_lanes[63:32];
                        o_wb_stb      <= 1'b1;
                        o_wb_we       <= i_wb_we;
                        o_wb_addr     <= {i_wb_addr[31:2], 2'b00};
                        o_wb_sel      <= w_mask[3:0];
                        o_mem_wb_data <= w_lanes[31:0];
                    end
                end
                REQ1: begin
                    if (!i_wb_stall) begin
                        o_wb_stb <= 1'b0;
                        r_state  <= WAIT1;
                    end
                end
                WAIT1: begin
                    if (i_wb_ack) begin
                        r_rd_lo <= i_mem_wb_data;
                        if (r_split) begin
                            r_state       <= REQ2;
                            o_wb_stb      <= 1'b1;
                            o_wb_addr     <= {r_word_hi, 2'b00};
                            o_wb_sel      <= r_sel_hi;
                            o_mem_wb_data <= r_data_hi;
                        end else begin
                            r_state   <= IDLE;
                            o_wb_ack  <= 1'b1;
                            o_wb_data <= o_wb_we ? 32'h0 : w_result;
                        end
                    end
                end
                REQ2: begin
                    if (!i_wb_stall) begin
                        o_wb_stb <= 1'b0;
                        r_state  <= WAIT2;
                    end
                end
                WAIT2: begin
                    if (i_wb_ack) begin
                        r_state   <= IDLE;
                        o_wb_ack  <= 1'b1;
                        o_wb_data <= o_wb_we ? 32'h0 : w_result;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// tb/tb_cpu_mem_ctrl.sv - self-checking bench for cpu_mem_ctrl with a byte-level reference model
module tb_cpu_mem_ctrl;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  sel   = '0;
    logic [31:0] o_data;
    logic        o_ack, o_stall;
    logic        m_stb, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_sel;
    logic [31:0] m_rdata = '0;
    logic        m_ack   = 1'b0;
    logic        m_stall;
    logic        stall_force = 1'b0, rnd_stall_en = 1'b0, rnd_bit = 1'b0, ack_block = 1'b0;
    int          cyc = 0, ack_count = 0, n_pass = 0, n_total = 0;

    always #5 clk = ~clk;
    assign m_stall = stall_force | (rnd_stall_en & rnd_bit);

    cpu_mem_ctrl dut (
        .i_clk(clk), .i_reset(rst_n), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdata), .i_sel(sel), .o_wb_data(o_data), .o_wb_ack(o_ack),
        .o_wb_stall(o_stall), .o_wb_stb(m_stb), .o_wb_we(m_we), .o_wb_addr(m_addr),
        .o_wb_sel(m_sel), .o_mem_wb_data(m_wdata), .i_mem_wb_data(m_rdata),
        .i_wb_ack(m_ack), .i_wb_stall(m_stall)
    );

    typedef struct packed { logic [31:0] a; logic [3:0] s; logic w; logic [31:0] d; } strobe_t;
    strobe_t    obs_q[$];
    logic [7:0] smem [0:511];

    // Pipelined slave: accepts a strobe when not stalled, acks it on the next cycle.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        if (o_ack) ack_count <= ack_count + 1;
        m_ack <= 1'b0;
        if (m_stb && !m_stall) begin
            obs_q.push_back({m_addr, m_sel, m_we, m_wdata});
            for (int b = 0; b < 4; b++) begin
                if (m_we && m_sel[b]) smem[m_addr[8:0] + 9'(b)] <= m_wdata[8*b +: 8];
                m_rdata[8*b +: 8] <= smem[m_addr[8:0] + 9'(b)];
            end
            m_ack <= !ack_block;
        end
    end

    always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1);
    end

    logic [7:0]  ref_mem [0:511];
    logic [31:0] e_a [2];
    logic [3:0]  e_s [2];
    logic [31:0] e_d [2];
    int          e_cnt;

    function automatic int nbytes(input logic [2:0] s);
        return (s[1:0] == 2'b00) ? 1 : (s[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Walks the access byte by byte, grouping bytes by the word they fall in.
    task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] s, output logic [31:0] res);
        int n, lane;
        logic [31:0] ba, v;
        n = nbytes(s); e_cnt = 0; v = '0;
        for (int i = 0; i < n; i++) begin
            ba   = a + 32'(i);
            lane = int'(ba[1:0]);
            if (e_cnt == 0 || e_a[e_cnt-1] != {ba[31:2], 2'b00}) begin
                e_a[e_cnt] = {ba[31:2], 2'b00}; e_s[e_cnt] = '0; e_d[e_cnt] = '0;
                e_cnt++;
            end
            e_s[e_cnt-1][lane] = 1'b1;
            if (w) begin
                e_d[e_cnt-1][8*lane +: 8] = d[8*i +: 8];
                ref_mem[ba[8:0]] = d[8*i +: 8];
            end else begin
                v[8*i +: 8] = ref_mem[ba[8:0]];
            end
        end
        if (w)           res = '0;
        else if (n == 1) res = s[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
        else if (n == 2) res = s[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        else             res = v;
    endtask

    function automatic bit strobes_ok(input int start, input logic w);
        if (obs_q.size() - start != e_cnt) return 1'b0;
        for (int j = 0; j < e_cnt; j++) begin
            if (obs_q[start+j].a !== e_a[j] || obs_q[start+j].s !== e_s[j] || obs_q[start+j].w !== w)
                return 1'b0;
            if (w && obs_q[start+j].d !== e_d[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    int          t_acc, q0, a0, r_lat, r_nack;
    logic [31:0] r_obs, r_exp;
    bit          r_sok;

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        @(negedge clk);
        q0 = obs_q.size(); a0 = ack_count;
        stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        @(negedge clk);
        stb = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; sel = 3'($urandom);
        t_acc = cyc;
    endtask

    task automatic wait_ack(output logic [31:0] res, output int lat);
        int guard = 0;
        while (o_ack !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        lat = (o_ack === 1'b1) ? cyc - t_acc + 1 : -1;
        res = o_data;
        @(negedge clk);
    endtask

    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        model(w, a, d, s, r_exp);
        issue(w, a, d, s);
        wait_ack(r_obs, r_lat);
        r_nack = ack_count - a0;
        r_sok  = strobes_ok(q0, w);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            stb = 1'($urandom); we = 1'($urandom); addr = $urandom; wdata = $urandom;
            sel = 3'($urandom); stall_force = 1'($urandom);
            #1;
            n_total++;
            if ({o_data, o_ack, o_stall, m_stb, m_we, m_addr, m_sel, m_wdata} !== '0)
                $display("FAIL reset_outputs: got %h required 0",
                         {o_data, o_ack, o_stall, m_stb, m_we, m_addr, m_sel, m_wdata});
            else n_pass++;
        end
        stb = 1'b0; stall_force = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (o_stall !== 1'b0 || o_ack !== 1'b0)
            $display("FAIL reset_release: got stall=%b ack=%b required 0 0", o_stall, o_ack);
        else n_pass++;
    endtask

    task automatic test_word();
        do_access(1'b1, 32'h100, 32'hDEADBEEF, 3'b010);
        n_total++;
        if (!r_sok || r_nack != 1 || obs_q[q0] !== {32'h100, 4'b1111, 1'b1, 32'hDEADBEEF})
            $display("FAIL sw_strobe: got %h acks=%0d required %h acks=1", obs_q[q0], r_nack,
                     {32'h100, 4'b1111, 1'b1, 32'hDEADBEEF});
        else n_pass++;
        do_access(1'b0, 32'h100, 32'h0, 3'b010);
        n_total++;
        if (r_obs !== 32'hDEADBEEF || r_lat != 3 || !r_sok)
            $display("FAIL lw_aligned: got %h lat=%0d required deadbeef lat=3", r_obs, r_lat);
        else n_pass++;
    endtask

    task automatic test_byte();
        do_access(1'b1, 32'h103, 32'h80, 3'b000);
        n_total++;
        if (r_nack != 1 || obs_q[q0] !== {32'h100, 4'b1000, 1'b1, 32'h80000000})
            $display("FAIL sb_strobe: got %h required %h", obs_q[q0], {32'h100, 4'b1000, 1'b1, 32'h80000000});
        else n_pass++;
        do_access(1'b0, 32'h103, 32'h0, 3'b000);
        n_total++;
        if (r_obs !== 32'hFFFFFF80 || r_lat != 3 || !r_sok)
            $display("FAIL lb_signed: got %h lat=%0d required ffffff80 lat=3", r_obs, r_lat);
        else n_pass++;
        do_access(1'b0, 32'h103, 32'h0, 3'b100);
        n_total++;
        if (r_obs !== 32'h00000080 || !r_sok)
            $display("FAIL lbu: got %h required 00000080", r_obs);
        else n_pass++;
    endtask

    task automatic test_half();
        do_access(1'b1, 32'h100, 32'h80011234, 3'b010);
        do_access(1'b0, 32'h102, 32'h0, 3'b001);
        n_total++;
        if (r_obs !== 32'hFFFF8001 || !r_sok) $display("FAIL lh_signed: got %h required ffff8001", r_obs);
        else n_pass++;
        do_access(1'b0, 32'h102, 32'h0, 3'b101);
        n_total++;
        if (r_obs !== 32'h00008001 || !r_sok) $display("FAIL lhu: got %h required 00008001", r_obs);
        else n_pass++;
        do_access(1'b0, 32'h100, 32'h0, 3'b001);
        n_total++;
        if (r_obs !== 32'h00001234 || obs_q[q0].s !== 4'b0011)
            $display("FAIL lh_low: got %h sel=%b required 00001234 sel=0011", r_obs, obs_q[q0].s);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        do_access(1'b1, 32'h100, 32'h44332211, 3'b010);
        do_access(1'b1, 32'h104, 32'h88776655, 3'b010);
        do_access(1'b0, 32'h101, 32'h0, 3'b010);
        n_total++;
        if (r_obs !== 32'h55443322 || r_nack != 1 || r_lat != 5 || obs_q.size() - q0 != 2 ||
            obs_q[q0].a !== 32'h100 || obs_q[q0].s !== 4'b1110 ||
            obs_q[q0+1].a !== 32'h104 || obs_q[q0+1].s !== 4'b0001)
            $display("FAIL lw_split: got %h acks=%0d lat=%0d required 55443322 acks=1 lat=5", r_obs, r_nack, r_lat);
        else n_pass++;
        do_access(1'b1, 32'h103, 32'hAABBCCDD, 3'b010);
        n_total++;
        if (r_nack != 1 || obs_q.size() - q0 != 2 ||
            obs_q[q0] !== {32'h100, 4'b1000, 1'b1, 32'hDD000000} ||
            obs_q[q0+1] !== {32'h104, 4'b0111, 1'b1, 32'h00AABBCC})
            $display("FAIL sw_split: got %h / %h required 100/1000/dd000000 then 104/0111/00aabbcc",
                     obs_q[q0], obs_q[q0+1]);
        else n_pass++;
        do_access(1'b0, 32'h103, 32'h0, 3'b001);
        n_total++;
        if (r_obs !== 32'hFFFFCCDD || r_lat != 5 || !r_sok)
            $display("FAIL lh_split: got %h lat=%0d required ffffccdd lat=5", r_obs, r_lat);
        else n_pass++;
    endtask

    task automatic test_stall();
        model(1'b0, 32'h104, 32'h0, 3'b010, r_exp);
        stall_force = 1'b1;
        issue(1'b0, 32'h104, 32'h0, 3'b010);
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (m_stb !== 1'b1 || m_addr !== 32'h104 || m_sel !== 4'b1111)
                $display("FAIL stall_hold: got stb=%b addr=%h sel=%b required 1 00000104 1111", m_stb, m_addr, m_sel);
            else n_pass++;
            if (k < 2) @(negedge clk);
        end
        stall_force = 1'b0;
        wait_ack(r_obs, r_lat);
        n_total++;
        if (r_obs !== r_exp || r_lat != 5 || ack_count - a0 != 1 || !strobes_ok(q0, 1'b0))
            $display("FAIL stall_result: got %h lat=%0d required %h lat=5", r_obs, r_lat, r_exp);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        model(1'b1, 32'h108, 32'h12345678, 3'b010, r_exp);
        issue(1'b1, 32'h108, 32'h12345678, 3'b010);
        stb = 1'b1; we = 1'b0; addr = 32'h10C; sel = 3'b010;
        repeat (2) @(negedge clk);
        stb = 1'b0;
        wait_ack(r_obs, r_lat);
        repeat (4) @(negedge clk);
        n_total++;
        if (ack_count - a0 != 1 || !strobes_ok(q0, 1'b1) || o_stall !== 1'b0)
            $display("FAIL busy_ignore: got acks=%0d strobes=%0d required acks=1 strobes=1",
                     ack_count - a0, obs_q.size() - q0);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        ack_block = 1'b1;
        issue(1'b0, 32'h100, 32'h0, 3'b010);
        @(negedge clk);
        n_total++;
        if (o_stall !== 1'b1) $display("FAIL wait1_busy: got stall=%b required 1", o_stall);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({o_data, o_ack, o_stall, m_stb, m_we, m_addr, m_sel, m_wdata} !== '0)
            $display("FAIL async_reset: got %h required 0", {o_data, o_ack, o_stall, m_stb, m_we, m_addr, m_sel, m_wdata});
        else n_pass++;
        ack_block = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_total++;
        if (ack_count - a0 != 0 || o_stall !== 1'b0)
            $display("FAIL abandon: got acks=%0d stall=%b required 0 0", ack_count - a0, o_stall);
        else n_pass++;
        do_access(1'b0, 32'h100, 32'h0, 3'b010);
        n_total++;
        if (r_obs !== r_exp || r_nack != 1) $display("FAIL post_reset: got %h required %h", r_obs, r_exp);
        else n_pass++;
    endtask

    task automatic test_random();
        int init_bad = 0;
        logic        w;
        logic [31:0] a, d;
        logic [2:0]  s;
        for (int i = 0; i < 16; i++) begin
            do_access(1'b1, 32'h100 + 32'(4 * i), $urandom, 3'b010);
            if (r_nack != 1 || !r_sok) init_bad++;
        end
        n_total++;
        if (init_bad != 0) $display("FAIL rand_init: got %0d bad stores required 0", init_bad);
        else n_pass++;
        for (int i = 0; i < 60; i++) begin
            rnd_stall_en = (i >= 30);
            w = 1'($urandom); a = 32'h100 + $urandom_range(0, 59); d = $urandom; s = 3'($urandom);
            do_access(w, a, d, s);
            n_total++;
            if (r_obs !== r_exp || r_nack != 1 || !r_sok)
                $display("FAIL rand_access: we=%b addr=%h sel=%b got %h acks=%0d strobes_ok=%b required %h acks=1",
                         w, a, s, r_obs, r_nack, r_sok, r_exp);
            else n_pass++;
            if (!rnd_stall_en) begin
                n_total++;
                if (r_lat != ((e_cnt == 2) ? 5 : 3))
                    $display("FAIL rand_latency: addr=%h sel=%b got %0d required %0d", a, s, r_lat, (e_cnt == 2) ? 5 : 3);
                else n_pass++;
            end
        end
        rnd_stall_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_stall();
        test_busy_ignore();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
